// File: rtl/bg_select_ctrl.sv
// ============================================================================
// bg_select_ctrl : background index selector, changes applied at frame start
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_select_ctrl #(
   parameter int NUM_BG      = 8,
   parameter int AUTO_FRAMES = 120,
   parameter int RESET_BG    = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start_i,
   input  logic       next_req_i,
   input  logic       prev_req_i,
   input  logic       set_valid_i,
   input  logic [2:0] set_bg_i,
   output logic       set_ready_o,
   input  logic       auto_en_i,
   output logic [2:0] bg_o,
   output logic       bg_update_o,
   output logic       pending_o
);

   localparam logic [1:0]  c_ST_IDLE   = 2'd0;
   localparam logic [1:0]  c_ST_STEP   = 2'd1;
   localparam logic [1:0]  c_ST_SET    = 2'd2;
   localparam logic [2:0]  c_LAST_BG   = 3'(NUM_BG - 1);
   localparam logic [2:0]  c_RESET_BG  = 3'(RESET_BG);
   localparam logic [3:0]  c_NUM_BG    = 4'(NUM_BG);
   localparam logic [11:0] c_AUTO_LAST = 12'(AUTO_FRAMES - 1);

   logic [1:0]  state_q,   state_d;
   logic        step_dn_q, step_dn_d;
   logic [2:0]  target_q,  target_d;
   logic [2:0]  bg_q,      bg_d;
   logic        upd_q,     upd_d;
   logic [11:0] cnt_q,     cnt_d;

   logic [2:0]  w_bg_inc;
   logic [2:0]  w_bg_dec;
   logic        w_apply;
   logic        w_auto_fire;
   logic        w_set_acc;

   assign w_bg_inc    = (bg_q == c_LAST_BG) ? 3'd0 : bg_q + 3'd1;
   assign w_bg_dec    = (bg_q == 3'd0) ? c_LAST_BG : bg_q - 3'd1;
   assign w_apply     = frame_start_i && (state_q != c_ST_IDLE);
   assign w_auto_fire = auto_en_i && frame_start_i && (state_q == c_ST_IDLE)
                        && (cnt_q == c_AUTO_LAST);
   assign w_set_acc   = set_valid_i && set_ready_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= c_ST_IDLE;
         step_dn_q <= 1'b0;
         target_q  <= 3'd0;
         bg_q      <= c_RESET_BG;
         upd_q     <= 1'b0;
         cnt_q     <= 12'd0;
      end else begin
         state_q   <= state_d;
         step_dn_q <= step_dn_d;
         target_q  <= target_d;
         bg_q      <= bg_d;
         upd_q     <= upd_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_dn_d = step_dn_q;
      target_d  = target_q;
      bg_d      = bg_q;
      cnt_d     = cnt_q;

      // Apply the queued request first; a capture below may re-queue for next frame
      if (w_apply) begin
         state_d = c_ST_IDLE;
         if (state_q == c_ST_SET) begin
            bg_d = target_q;
         end else begin
            bg_d = step_dn_q ? w_bg_dec : w_bg_inc;
         end
      end else if (w_auto_fire) begin
         bg_d = w_bg_inc;
      end

      if (!auto_en_i || w_apply || w_auto_fire) begin
         cnt_d = 12'd0;
      end else if (frame_start_i) begin
         cnt_d = cnt_q + 12'd1;
      end

      if (w_set_acc) begin
         if ({1'b0, set_bg_i} < c_NUM_BG) begin
            state_d  = c_ST_SET;
            target_d = set_bg_i;
         end
      end else if ((next_req_i ^ prev_req_i) && (state_q != c_ST_SET)) begin
         state_d   = c_ST_STEP;
         step_dn_d = prev_req_i;
      end

      upd_d = (bg_d != bg_q);
   end

   always_comb begin
      set_ready_o = (state_q != c_ST_SET);
      pending_o   = (state_q != c_ST_IDLE);
      bg_o        = bg_q;
      bg_update_o = upd_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_bg_select_ctrl.sv
// ============================================================================
// tb_bg_select_ctrl : directed bench for bg_select_ctrl (three configurations)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bg_select_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start, next_req, prev_req, set_valid, auto_en;
   logic [2:0] set_bg;

   logic       a_rdy, b_rdy, c_rdy;
   logic [2:0] a_bg, b_bg, c_bg;
   logic       a_upd, b_upd, c_upd;
   logic       a_pnd, b_pnd, c_pnd;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bg_select_ctrl #(.NUM_BG(8), .AUTO_FRAMES(4), .RESET_BG(0)) u_a (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .next_req_i(next_req),
      .prev_req_i(prev_req), .set_valid_i(set_valid), .set_bg_i(set_bg),
      .set_ready_o(a_rdy), .auto_en_i(auto_en), .bg_o(a_bg),
      .bg_update_o(a_upd), .pending_o(a_pnd));

   bg_select_ctrl #(.NUM_BG(5), .AUTO_FRAMES(4), .RESET_BG(0)) u_b (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .next_req_i(next_req),
      .prev_req_i(prev_req), .set_valid_i(set_valid), .set_bg_i(set_bg),
      .set_ready_o(b_rdy), .auto_en_i(auto_en), .bg_o(b_bg),
      .bg_update_o(b_upd), .pending_o(b_pnd));

   bg_select_ctrl #(.NUM_BG(6), .AUTO_FRAMES(4), .RESET_BG(3)) u_c (
      .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start), .next_req_i(next_req),
      .prev_req_i(prev_req), .set_valid_i(set_valid), .set_bg_i(set_bg),
      .set_ready_o(c_rdy), .auto_en_i(auto_en), .bg_o(c_bg),
      .bg_update_o(c_upd), .pending_o(c_pnd));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   task automatic req_next();
      next_req = 1'b1;
      cyc();
      next_req = 1'b0;
   endtask

   task automatic req_prev();
      prev_req = 1'b1;
      cyc();
      prev_req = 1'b0;
   endtask

   task automatic req_set(input logic [2:0] v);
      set_valid = 1'b1;
      set_bg    = v;
      cyc();
      set_valid = 1'b0;
      set_bg    = 3'd0;
   endtask

   initial begin
      rst_n = 1'b0; frame_start = 1'b0; next_req = 1'b0; prev_req = 1'b0;
      set_valid = 1'b0; set_bg = 3'd0; auto_en = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;

      chk("rst_bg", a_bg, 0);
      chk("rst_ready", a_rdy, 1);
      chk("rst_pending", a_pnd, 0);
      chk("rst_update", a_upd, 0);
      chk("rst_bg_resetbg3", c_bg, 3);

      // request early, frame much later: nothing moves until the frame
      for (int i = 0; i < 9; i++) cyc();
      req_next();
      chk("next_pending", a_pnd, 1);
      for (int i = 0; i < 38; i++) begin
         cyc();
         chk("hold_bg", a_bg, 0);
         chk("hold_upd", a_upd, 0);
      end
      pulse();
      chk("next_bg", a_bg, 1);
      chk("next_upd", a_upd, 1);
      cyc();
      chk("upd_one_cycle", a_upd, 0);
      chk("next_pending_clr", a_pnd, 0);

      // wrap in both directions at NUM_BG=8
      req_set(3'd7);
      chk("set_ready_low", a_rdy, 0);
      pulse();
      chk("set7_bg", a_bg, 7);
      chk("set_ready_back", a_rdy, 1);
      req_next();
      pulse();
      chk("wrap_up_bg", a_bg, 0);
      chk("wrap_up_upd", a_upd, 1);
      req_prev();
      pulse();
      chk("wrap_dn_bg", a_bg, 7);

      // set has priority over a later step
      req_set(3'd5);
      chk("set5_ready", a_rdy, 0);
      chk("set5_pending", a_pnd, 1);
      req_next();
      pulse();
      chk("set5_bg", a_bg, 5);
      chk("set5_ready_after", a_rdy, 1);
      chk("set5_pending_after", a_pnd, 0);
      cyc();
      pulse();
      chk("step_dropped_bg", a_bg, 5);

      // set to the current value: no update pulse
      req_set(3'd5);
      pulse();
      chk("same_set_bg", a_bg, 5);
      chk("same_set_upd", a_upd, 0);

      // next and prev together cancel
      next_req = 1'b1; prev_req = 1'b1;
      cyc();
      next_req = 1'b0; prev_req = 1'b0;
      chk("cancel_pending", a_pnd, 0);
      pulse();
      chk("cancel_bg", a_bg, 5);

      // request in a frame_start cycle waits for the following frame
      next_req = 1'b1; frame_start = 1'b1;
      cyc();
      next_req = 1'b0; frame_start = 1'b0;
      chk("fs_req_bg", a_bg, 5);
      chk("fs_req_pending", a_pnd, 1);
      cyc();
      pulse();
      chk("fs_req_bg_next", a_bg, 6);

      // auto mode, AUTO_FRAMES=4, manual prev applied at pulse 6
      auto_en = 1'b1;
      cyc();
      for (int p = 1; p <= 14; p++) begin
         logic [2:0] exp_bg;
         if (p == 6) req_prev();
         pulse();
         if (p < 4)        exp_bg = 3'd6;
         else if (p < 6)   exp_bg = 3'd7;
         else if (p < 10)  exp_bg = 3'd6;
         else if (p < 14)  exp_bg = 3'd7;
         else              exp_bg = 3'd0;
         chk($sformatf("auto_p%0d", p), a_bg, exp_bg);
         cyc();
      end
      auto_en = 1'b0;
      cyc();
      pulse();
      chk("auto_off_bg", a_bg, 0);

      // reset while a set is queued
      req_set(3'd3);
      chk("pre_rst_pending", a_pnd, 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("midrst_bg", a_bg, 0);
      chk("midrst_pending", a_pnd, 0);
      chk("midrst_ready", a_rdy, 1);
      chk("midrst_bg_c", c_bg, 3);
      pulse();
      chk("midrst_frame_bg", a_bg, 0);
      chk("midrst_frame_upd", a_upd, 0);

      // NUM_BG=5 wrap from 4 and NUM_BG=6 out-of-range set
      req_set(3'd4);
      pulse();
      chk("n5_set4", b_bg, 4);
      req_next();
      pulse();
      chk("n5_wrap", b_bg, 0);
      chk("n5_wrap_upd", b_upd, 1);
      chk("n6_bg", c_bg, 5);
      req_set(3'd6);
      chk("n6_discard_pending", c_pnd, 0);
      chk("n6_discard_ready", c_rdy, 1);
      pulse();
      chk("n6_discard_bg", c_bg, 5);
      chk("n8_set6_bg", a_bg, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bg_select_ctrl.md
Name: bg_select_ctrl

Overview:
Produces the 3-bit background index that drives the background colour mux in the VGA display path. It collects user and game requests (next, previous, direct set) and an optional auto-cycle mode. The index changes only at a frame boundary, so the picture never changes background mid-frame.

Parameters:
NUM_BG, 8, number of valid backgrounds (1..8); legal indices are 0..NUM_BG-1
AUTO_FRAMES, 120, frames between automatic advances when auto_en=1 (2..4095)
RESET_BG, 0, index loaded at reset (must be < NUM_BG)

Ports:
clk  input  1  system/pixel clock
rst_n  input  1  synchronous active-low reset
frame_start  input  1  one-cycle pulse at start of vertical blank
next_req  input  1  one-cycle pulse: advance to next background
prev_req  input  1  one-cycle pulse: go to previous background
set_valid  input  1  direct-set request valid
set_bg  input  3  requested index, qualified by set_valid
set_ready  output  1  high when a direct-set request can be accepted
auto_en  input  1  level: enable auto-cycling
bg  output  3  current background index (to colour mux select)
bg_update  output  1  one-cycle pulse in the first cycle the new bg is visible
pending  output  1  a request is waiting for the next frame_start

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-low (rst_n sampled on rising clk). All state is registered.
- Reset values: bg=RESET_BG, bg_update=0, pending=0, set_ready=1, frame counter=0, state=IDLE.
- State machine (pending-request register):
  - IDLE: no request queued.
  - PEND_STEP: a signed step of +1 or -1 is queued.
  - PEND_SET: a target index is queued.
- Request capture (any cycle, including a frame_start cycle):
  - set_valid & set_ready: handshake completes. If set_bg < NUM_BG, go to PEND_SET with target=set_bg. Otherwise discard, state unchanged.
  - next_req xor prev_req, not in PEND_SET: go to PEND_STEP with step=+1 or -1. A later step overwrites an earlier one (last request wins; no accumulation).
  - next_req & prev_req in the same cycle: cancel each other; no change.
  - Step requests while in PEND_SET are dropped (set has priority).
  - set_valid with a step in the same cycle: set wins.
- set_ready = 1 in IDLE and PEND_STEP; 0 in PEND_SET. Deasserts the cycle after acceptance. Reasserts the cycle after the set is applied.
- Apply (the cycle frame_start=1): the registered result appears on the next edge.
  - PEND_STEP: bg = (bg+1) mod NUM_BG or (bg-1) mod NUM_BG. Wrap: NUM_BG-1 to 0, and 0 to NUM_BG-1.
  - PEND_SET: bg = target.
  - State returns to IDLE.
  - A request captured in the same cycle as frame_start is queued for the following frame, not applied now.
- bg_update=1 for exactly one cycle (the cycle after frame_start) only if the new bg differs from the old one. Setting the current value, or NUM_BG=1, gives no pulse.
- Auto mode (auto_en=1):
  - The frame counter increments on each frame_start.
  - When it reaches AUTO_FRAMES-1 and state is IDLE, that frame_start applies +1 and the counter clears.
  - Any manual application also clears the counter.
  - auto_en=0 holds the counter at 0.
  - When auto and manual coincide, manual wins.
- pending = (state != IDLE).
- Reset mid-operation: a queued request is discarded, bg returns to RESET_BG, set_ready returns to 1.
- Latency: request to visible change = 1 cycle after the next frame_start (or the one after, if captured in the frame_start cycle).

Test Plan:
- Reset with RESET_BG=0 -> bg=0, set_ready=1, pending=0. next_req at cycle 10, frame_start at cycle 50 -> bg=1 at cycle 51, bg_update high only at cycle 51, no change before.
- bg=7, NUM_BG=8: next_req then frame_start -> bg=0. Then prev_req then frame_start -> bg=7. With NUM_BG=5 and bg=4, next -> 0.
- set_valid with set_bg=5 -> set_ready low next cycle. Then next_req -> ignored. frame_start -> bg=5, set_ready high the following cycle. set_bg=6 with NUM_BG=6 -> discarded, pending stays 0.
- next_req and prev_req in the same cycle -> pending=0, bg unchanged. next_req in the same cycle as frame_start -> bg unchanged at that frame, changes at the next frame_start.
- auto_en=1, AUTO_FRAMES=4, 12 frame_start pulses -> bg increments at pulses 4, 8, 12. A manual prev at pulse 6 resets the count so the next auto advance is at pulse 10.
- rst_n low for one cycle while in PEND_SET -> bg=RESET_BG, pending=0, set_ready=1. A later frame_start causes no change.
